// File: rtl/idct_pass_engine_pkg.sv
// Shared types and constants for the IDCT pass engine: FSM states, mode codes
// and the cosine coefficient tables for N=8 and N=4.
package idct_pass_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  // round(4096*sqrt(2/N)*cos(m*pi/(2N))) for the first quadrant; DC column separate.
  localparam int COS8_TAB [0:8] = '{2048, 2009, 1892, 1703, 1448, 1138, 784, 400, 0};
  localparam int DC8 = 1448;
  localparam int COS4_TAB [0:4] = '{2896, 2676, 2048, 1108, 0};
  localparam int DC4 = 2048;

  // C[r][c] built from the quadrant table using cosine symmetry.
  function automatic int idct_coef(input int n, input int r, input int c);
    int  m;
    int  period;
    int  mag;
    bit  neg;
    period = 4 * n;
    neg    = 1'b0;
    if (c == 0) begin
      return (n == 4) ? DC4 : DC8;
    end
    m = ((2 * r + 1) * c) % period;
    if (m > 2 * n) m = period - m;
    if (m > n) begin
      m   = 2 * n - m;
      neg = 1'b1;
    end
    mag = (n == 4) ? COS4_TAB[m] : COS8_TAB[m];
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/Multiplier.sv
// Signed combinational multiplier; full-width product.
module Multiplier #(
  parameter int A_W = 16,
  parameter int B_W = 13
) (
  input  logic signed [A_W-1:0]     op_a,
  input  logic signed [B_W-1:0]     op_b,
  output logic signed [A_W+B_W-1:0] product
);

  assign product = op_a * op_b;

endmodule

// File: rtl/idct_coef_rom.sv
// Combinational cosine coefficient ROM: coef = C[k][col].
module idct_coef_rom
  import idct_pass_engine_pkg::*;
#(
  parameter int N      = 8,
  parameter int COEF_W = 13,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic [IDX_W-1:0]         k,
  input  logic [IDX_W-1:0]         col,
  output logic signed [COEF_W-1:0] coef
);

  always_comb begin
    coef = COEF_W'(idct_coef(N, int'(k), int'(col)));
  end

endmodule

// File: rtl/idct_pass_engine.sv
// One-pass NxN IDCT matrix engine: row pass T=A*C or column pass S=C^T*A,
// LANES outputs per group, results scaled and written back one word per cycle.
module idct_pass_engine
  import idct_pass_engine_pkg::*;
#(
  parameter int N         = 8,
  parameter int LANES     = 2,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 13,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int SHIFT_ROW = 8,
  parameter int SHIFT_COL = 16
) (
  input  logic                      CLOCK_50_I,
  input  logic                      Resetn,
  input  logic                      start,
  input  logic                      mode,
  output logic                      busy,
  output logic                      done,
  output logic [2*$clog2(N)-1:0]    rd_addr,
  input  logic signed [DATA_W-1:0]  rd_data,
  output logic [2*$clog2(N)-1:0]    wr_addr,
  output logic [OUT_W-1:0]          wr_data,
  output logic                      wr_en
);

  localparam int IDX_W  = $clog2(N);
  localparam int ADDR_W = 2 * IDX_W;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int DL_W   = $clog2(LANES) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] CLIP_MAX = ACC_W'(255);

  state_t state_reg, state_next;
  logic   mode_reg;

  // Issue position: k innermost, then group base b, then outer index o.
  logic [IDX_W-1:0] k_reg, b_reg, o_reg;
  logic [IDX_W-1:0] k_next, b_next, o_next;
  logic             issue_last;
  logic [ADDR_W-1:0] rd_addr_reg;

  // Position of the read whose data is on rd_data this cycle.
  logic             valid_d_reg;
  logic [IDX_W-1:0] k_d_reg, b_d_reg, o_d_reg;
  logic             group_end;

  logic signed [ACC_W-1:0] acc_reg       [LANES];
  logic signed [ACC_W-1:0] sum           [LANES];
  logic signed [ACC_W-1:0] drain_buf_reg [LANES];
  logic [IDX_W-1:0]        drain_b_reg, drain_o_reg;
  logic [DL_W-1:0]         drain_lane_reg;
  logic signed [ACC_W-1:0] drain_word;
  logic [IDX_W-1:0]        drain_col;
  logic [ADDR_W-1:0]       drain_addr;

  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [OUT_W-1:0]  wr_data_reg;

  function automatic logic [OUT_W-1:0] format_word(input logic signed [ACC_W-1:0] acc,
                                                   input logic md);
    logic signed [ACC_W-1:0] sh;
    format_word = '0;
    if (md == MODE_ROW) begin
      sh = acc >>> SHIFT_ROW;
      if (sh > SAT_MAX)      format_word = SAT_MAX[OUT_W-1:0];
      else if (sh < SAT_MIN) format_word = SAT_MIN[OUT_W-1:0];
      else                   format_word = sh[OUT_W-1:0];
    end else begin
      sh = acc >>> SHIFT_COL;
      if (sh[ACC_W-1])        format_word = '0;
      else if (sh > CLIP_MAX) format_word = OUT_W'(8'hFF);
      else                    format_word = OUT_W'(sh[7:0]);
    end
  endfunction

  assign busy    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done    = (state_reg == ST_DONE);
  assign rd_addr = rd_addr_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign wr_en   = wr_en_reg;

  assign issue_last = (k_reg == IDX_W'(N-1)) && (b_reg == IDX_W'(N-LANES)) &&
                      (o_reg == IDX_W'(N-1));
  assign group_end  = valid_d_reg && (k_d_reg == IDX_W'(N-1));

  always_comb begin
    k_next = k_reg + IDX_W'(1);
    b_next = b_reg;
    o_next = o_reg;
    if (k_reg == IDX_W'(N-1)) begin
      k_next = '0;
      if (b_reg == IDX_W'(N-LANES)) begin
        b_next = '0;
        o_next = o_reg + IDX_W'(1);
      end else begin
        b_next = b_reg + IDX_W'(LANES);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IDX_W-1:0]         rom_col;
      logic signed [COEF_W-1:0] coef;
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_W-1:0]  prod_ext;
      logic signed [ACC_W-1:0]  acc_base;

      assign rom_col = b_d_reg + IDX_W'(gi);

      idct_coef_rom #(.N(N), .COEF_W(COEF_W)) u_rom (
        .k    (k_d_reg),
        .col  (rom_col),
        .coef (coef)
      );

      Multiplier #(.A_W(DATA_W), .B_W(COEF_W)) u_mul (
        .op_a    (rd_data),
        .op_b    (coef),
        .product (prod)
      );

      assign prod_ext = ACC_W'(prod);
      // k=0 starts a fresh group, so the previous sum is discarded in-line.
      assign acc_base = (k_d_reg == '0) ? '0 : acc_reg[gi];
      assign sum[gi]  = acc_base + prod_ext;
    end
  endgenerate

  always_comb begin
    drain_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (drain_lane_reg == DL_W'(l)) drain_word = drain_buf_reg[l];
    end
    drain_col  = drain_b_reg + IDX_W'(drain_lane_reg);
    drain_addr = (mode_reg == MODE_COL) ? {drain_col, drain_o_reg} : {drain_o_reg, drain_col};
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (issue_last) state_next = ST_DRAIN;
      ST_DRAIN: if (!valid_d_reg && (drain_lane_reg == DL_W'(LANES))) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      mode_reg       <= MODE_ROW;
      k_reg          <= '0;
      b_reg          <= '0;
      o_reg          <= '0;
      rd_addr_reg    <= '0;
      valid_d_reg    <= 1'b0;
      k_d_reg        <= '0;
      b_d_reg        <= '0;
      o_d_reg        <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_reg[l]       <= '0;
        drain_buf_reg[l] <= '0;
      end
      drain_b_reg    <= '0;
      drain_o_reg    <= '0;
      drain_lane_reg <= DL_W'(LANES);
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      valid_d_reg <= (state_reg == ST_RUN);

      if ((state_reg == ST_IDLE) && start) begin
        mode_reg    <= mode;
        k_reg       <= '0;
        b_reg       <= '0;
        o_reg       <= '0;
        rd_addr_reg <= '0;
      end

      if (state_reg == ST_RUN) begin
        k_d_reg     <= k_reg;
        b_d_reg     <= b_reg;
        o_d_reg     <= o_reg;
        k_reg       <= k_next;
        b_reg       <= b_next;
        o_reg       <= o_next;
        rd_addr_reg <= (mode_reg == MODE_COL) ? {k_next, o_next} : {o_next, k_next};
      end

      if (valid_d_reg) begin
        for (int l = 0; l < LANES; l++) acc_reg[l] <= sum[l];
      end

      // Lane 0 goes out directly; the remaining lanes follow from the drain buffer.
      if (group_end) begin
        wr_en_reg      <= 1'b1;
        wr_addr_reg    <= (mode_reg == MODE_COL) ? {b_d_reg, o_d_reg} : {o_d_reg, b_d_reg};
        wr_data_reg    <= format_word(sum[0], mode_reg);
        for (int l = 0; l < LANES; l++) drain_buf_reg[l] <= sum[l];
        drain_b_reg    <= b_d_reg;
        drain_o_reg    <= o_d_reg;
        drain_lane_reg <= DL_W'(1);
      end else if (drain_lane_reg != DL_W'(LANES)) begin
        wr_en_reg      <= 1'b1;
        wr_addr_reg    <= drain_addr;
        wr_data_reg    <= format_word(drain_word, mode_reg);
        drain_lane_reg <= drain_lane_reg + DL_W'(1);
      end else begin
        wr_en_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idct_pass_engine.sv
// Scoreboard bench for idct_pass_engine: two instances (LANES=2 and LANES=1)
// share one sample memory; expected writes are queued per pass and popped on wr_en.
module tb_idct_pass_engine;

  localparam int N  = 8;
  localparam int AW = 6;

  logic CLOCK_50_I = 1'b0;
  logic Resetn     = 1'b0;
  always #10 CLOCK_50_I = ~CLOCK_50_I;

  logic start0 = 1'b0, start1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
  logic busy0, busy1, done0, done1, wr_en0, wr_en1;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic signed [15:0] rd_data0, rd_data1;
  logic [15:0] wr_data0, wr_data1;

  logic signed [15:0] mem [64];

  always @(posedge CLOCK_50_I) begin
    rd_data0 <= mem[rd_addr0];
    rd_data1 <= mem[rd_addr1];
  end

  idct_pass_engine #(.N(8), .LANES(2)) dut0 (
    .CLOCK_50_I (CLOCK_50_I), .Resetn (Resetn), .start (start0), .mode (mode0),
    .busy (busy0), .done (done0), .rd_addr (rd_addr0), .rd_data (rd_data0),
    .wr_addr (wr_addr0), .wr_data (wr_data0), .wr_en (wr_en0)
  );

  idct_pass_engine #(.N(8), .LANES(1)) dut1 (
    .CLOCK_50_I (CLOCK_50_I), .Resetn (Resetn), .start (start1), .mode (mode1),
    .busy (busy1), .done (done1), .rd_addr (rd_addr1), .rd_data (rd_data1),
    .wr_addr (wr_addr1), .wr_data (wr_data1), .wr_en (wr_en1)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q0[$];
  wr_t exp_q1[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_cnt   [2];
  int  done_cnt [2];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50_I) begin
    wr_t e;
    if (done0) done_cnt[0]++;
    if (done1) done_cnt[1]++;
    if (wr_en0) begin
      wr_cnt[0]++;
      if (exp_q0.size() == 0) check_val("spurious_wr0", wr_en0, 0);
      else begin
        e = exp_q0.pop_front();
        check_val("wr_addr0", wr_addr0, e.addr);
        check_val("wr_data0", $signed(wr_data0), $signed(e.data));
      end
    end
    if (wr_en1) begin
      wr_cnt[1]++;
      if (exp_q1.size() == 0) check_val("spurious_wr1", wr_en1, 0);
      else begin
        e = exp_q1.pop_front();
        check_val("wr_addr1", wr_addr1, e.addr);
        check_val("wr_data1", $signed(wr_data1), $signed(e.data));
      end
    end
  end

  function automatic int coef(input int r, input int c);
    real s, x;
    s = (c == 0) ? $sqrt(1.0 / 8.0) : $sqrt(2.0 / 8.0);
    x = 4096.0 * s * $cos(real'((2 * r + 1) * c) * 3.14159265358979 / 16.0);
    return (x >= 0.0) ? $rtoi($floor(x + 0.5)) : -$rtoi($floor(-x + 0.5));
  endfunction

  task automatic build_exp(input int sel, input bit md);
    int     res [64];
    longint acc;
    int     a32, v, lanes, addr;
    wr_t    w;
    lanes = sel ? 1 : 2;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          if (!md) acc += longint'(mem[i*N+k]) * coef(k, j);
          else     acc += longint'(coef(k, i)) * mem[k*N+j];
        end
        a32 = int'(acc);
        if (!md) begin
          v = a32 >>> 8;
          if (v > 32767) v = 32767;
          if (v < -32768) v = -32768;
        end else begin
          v = a32 >>> 16;
          if (v > 255) v = 255;
          if (v < 0) v = 0;
        end
        res[i*N+j] = v;
      end
    end
    for (int o = 0; o < N; o++) begin
      for (int b = 0; b < N; b += lanes) begin
        for (int l = 0; l < lanes; l++) begin
          addr   = md ? (b + l) * N + o : o * N + b + l;
          w.addr = 6'(addr);
          w.data = 16'(res[addr]);
          if (sel != 0) exp_q1.push_back(w);
          else          exp_q0.push_back(w);
        end
      end
    end
  endtask

  // pattern: 0 zero, 1 A[0][0]=val, 2 column 0 = val, 3 random in [-4000,4000]
  task automatic fill_mem(input int pattern, input int val);
    int t;
    for (int i = 0; i < 64; i++) begin
      t = int'($urandom_range(8000)) - 4000;
      case (pattern)
        1:       mem[i] = (i == 0) ? 16'(val) : 16'sd0;
        2:       mem[i] = (i % N == 0) ? 16'(val) : 16'sd0;
        3:       mem[i] = 16'(t);
        default: mem[i] = 16'sd0;
      endcase
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic md);
    if (sel != 0) begin start1 = st; mode1 = md; end
    else          begin start0 = st; mode0 = md; end
  endtask

  function automatic logic sel_busy(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction

  function automatic logic sel_done(input int sel);
    return (sel != 0) ? done1 : done0;
  endfunction

  task automatic run_pass(input int sel, input bit md, input int exp_done,
                          input bit repulse, input int rst_at);
    int cyc;
    bit seen;
    wr_cnt[sel]   = 0;
    done_cnt[sel] = 0;
    build_exp(sel, md);
    @(negedge CLOCK_50_I);
    drive(sel, 1'b1, md);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 2000) begin
      @(negedge CLOCK_50_I);
      cyc++;
      if (cyc == 1) begin
        drive(sel, 1'b0, md);
        check_val("busy_cycle1", sel_busy(sel), 1);
      end
      if (repulse && cyc == 50) drive(sel, 1'b1, ~md);
      if (repulse && cyc == 51) drive(sel, 1'b0, md);
      if (cyc == rst_at) begin
        #2 Resetn = 1'b0;
        #1 check_val("reset_outputs",
                     {busy0, done0, wr_en0, rd_addr0, wr_addr0, wr_data0}, 0);
        repeat (3) @(negedge CLOCK_50_I);
        check_val("reset_no_done", done_cnt[sel], 0);
        Resetn = 1'b1;
        if (sel != 0) exp_q1.delete();
        else          exp_q0.delete();
        $display("pass dut%0d mode=%0d aborted by reset at cycle %0d", sel, md, cyc);
        return;
      end
      if (sel_done(sel)) seen = 1;
    end
    check_val("done_cycle", cyc, exp_done);
    check_val("busy_at_done", sel_busy(sel), 0);
    repeat (3) @(negedge CLOCK_50_I);
    check_val("write_count", wr_cnt[sel], 64);
    check_val("done_count", done_cnt[sel], 1);
    check_val("queue_left", (sel != 0) ? exp_q1.size() : exp_q0.size(), 0);
    $display("pass dut%0d mode=%0d done_cycle=%0d writes=%0d", sel, md, cyc, wr_cnt[sel]);
  endtask

  initial begin
    fill_mem(0, 0);
    #5;
    check_val("reset_state0", {busy0, done0, wr_en0, rd_addr0, wr_addr0, wr_data0}, 0);
    check_val("reset_state1", {busy1, done1, wr_en1, rd_addr1, wr_addr1, wr_data1}, 0);
    repeat (3) @(negedge CLOCK_50_I);
    Resetn = 1'b1;

    run_pass(0, 1'b0, 260, 1'b0, -1);
    fill_mem(1, 256);
    run_pass(0, 1'b0, 260, 1'b0, -1);
    run_pass(1, 1'b0, 515, 1'b0, -1);
    fill_mem(1, 32767);
    run_pass(0, 1'b1, 260, 1'b0, -1);
    fill_mem(1, -32768);
    run_pass(0, 1'b1, 260, 1'b0, -1);
    fill_mem(0, 0);
    run_pass(0, 1'b1, 260, 1'b0, -1);
    fill_mem(2, 32767);
    run_pass(0, 1'b0, 260, 1'b0, -1);
    fill_mem(2, -32768);
    run_pass(0, 1'b0, 260, 1'b0, -1);
    fill_mem(3, 0);
    run_pass(0, 1'b0, 260, 1'b0, -1);
    run_pass(0, 1'b1, 260, 1'b0, -1);
    run_pass(1, 1'b1, 515, 1'b0, -1);
    run_pass(0, 1'b0, 260, 1'b1, -1);
    run_pass(0, 1'b1, 0, 1'b0, 100);
    run_pass(0, 1'b1, 260, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
